// File: rtl/cpu_ctrl_pkg.sv
// Shared decode constants and control-word types for the decode/control pipeline.
// Opcode and funct values follow the MIPS-I encoding. ALU codes are 4 bits.
package cpu_ctrl_pkg;

    // Primary opcodes, taken from instr[31:26]
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes, taken from instr[5:0]
    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_SLLV  = 6'h04;
    localparam logic [5:0] FN_SRLV  = 6'h06;
    localparam logic [5:0] FN_SRAV  = 6'h07;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    // ALU operation codes
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SRA  = 4'b1000;
    localparam logic [3:0] ALU_BEQ  = 4'b1001;
    localparam logic [3:0] ALU_BNE  = 4'b1010;
    localparam logic [3:0] ALU_ILL  = 4'b1011;
    localparam logic [3:0] ALU_NOR  = 4'b1100;

    // Decoded control bits for one instruction
    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_write;
        logic       branch;
        logic       branch_ne;
        logic       jump;
        logic       jump_reg;
        logic       link;
        logic       alu_src;
        logic       alu_src_shamt;
        logic       reg_dst;
        logic [3:0] alu_ctrl;
    } ctrl_word_t;

    // One pipeline slot: qualifier, illegal flag and the control word
    typedef struct packed {
        logic       valid;
        logic       illegal;
        ctrl_word_t ctrl;
    } stage_t;

    localparam ctrl_word_t CTRL_NOP    = '0;
    localparam stage_t     STAGE_EMPTY = '0;

    // Register-to-register ALU op writing rd; shamt selects the shift-amount operand
    function automatic ctrl_word_t r_alu(input logic [3:0] alu, input logic use_shamt);
        ctrl_word_t w;
        w               = CTRL_NOP;
        w.reg_write     = 1'b1;
        w.reg_dst       = 1'b1;
        w.alu_src_shamt = use_shamt;
        w.alu_ctrl      = alu;
        return w;
    endfunction

    // Immediate ALU op writing rt
    function automatic ctrl_word_t i_alu(input logic [3:0] alu);
        ctrl_word_t w;
        w           = CTRL_NOP;
        w.reg_write = 1'b1;
        w.alu_src   = 1'b1;
        w.alu_ctrl  = alu;
        return w;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decoder: maps a 32-bit instruction to a control
// word plus an illegal flag. Unrecognised encodings produce no side effects.
module ctrl_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [31:0] instr,
    output ctrl_word_t  ctrl,
    output logic        illegal
);

    logic [5:0] op;
    logic [5:0] funct;
    // Register and immediate fields do not influence control decode
    logic       unused_fields;

    assign op            = instr[31:26];
    assign funct         = instr[5:0];
    assign unused_fields = ^instr[25:6];

    // Decode opcode, then funct for R-type; anything else is illegal
    always_comb begin
        ctrl    = CTRL_NOP;
        illegal = 1'b0;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD, FN_ADDU: ctrl = r_alu(ALU_ADD, 1'b0);
                    FN_SUB, FN_SUBU: ctrl = r_alu(ALU_SUB, 1'b0);
                    FN_AND:          ctrl = r_alu(ALU_AND, 1'b0);
                    FN_OR:           ctrl = r_alu(ALU_OR,  1'b0);
                    FN_XOR:          ctrl = r_alu(ALU_XOR, 1'b0);
                    FN_NOR:          ctrl = r_alu(ALU_NOR, 1'b0);
                    FN_SLT:          ctrl = r_alu(ALU_SLT, 1'b0);
                    FN_SLL:          ctrl = r_alu(ALU_SLL, 1'b1);
                    FN_SRL:          ctrl = r_alu(ALU_SRL, 1'b1);
                    FN_SRA:          ctrl = r_alu(ALU_SRA, 1'b1);
                    FN_SLLV:         ctrl = r_alu(ALU_SLL, 1'b0);
                    FN_SRLV:         ctrl = r_alu(ALU_SRL, 1'b0);
                    FN_SRAV:         ctrl = r_alu(ALU_SRA, 1'b0);
                    FN_JR: begin
                        ctrl.jump_reg = 1'b1;
                        ctrl.alu_ctrl = ALU_AND;
                    end
                    default: begin
                        illegal       = 1'b1;
                        ctrl.alu_ctrl = ALU_ILL;
                    end
                endcase
            end
            OP_ADDI, OP_ADDIU: ctrl = i_alu(ALU_ADD);
            OP_ANDI:           ctrl = i_alu(ALU_AND);
            OP_ORI:            ctrl = i_alu(ALU_OR);
            OP_XORI:           ctrl = i_alu(ALU_XOR);
            OP_LW: begin
                ctrl            = i_alu(ALU_ADD);
                ctrl.mem_to_reg = 1'b1;
            end
            OP_SW: begin
                ctrl.mem_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_ctrl  = ALU_ADD;
            end
            OP_BEQ: begin
                ctrl.branch   = 1'b1;
                ctrl.alu_ctrl = ALU_BEQ;
            end
            OP_BNE: begin
                ctrl.branch    = 1'b1;
                ctrl.branch_ne = 1'b1;
                ctrl.alu_ctrl  = ALU_BNE;
            end
            OP_J: begin
                ctrl.jump     = 1'b1;
                ctrl.alu_ctrl = ALU_AND;
            end
            OP_JAL: begin
                ctrl.jump      = 1'b1;
                ctrl.link      = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.alu_ctrl  = ALU_AND;
            end
            default: begin
                illegal       = 1'b1;
                ctrl.alu_ctrl = ALU_ILL;
            end
        endcase
    end

endmodule

// File: rtl/decode_control_pipe.sv
// Decode stage followed by a STAGES-deep control register chain. Stall holds
// the whole chain, flush empties it, reset clears everything. A saturating
// counter tracks illegal instructions accepted into the first stage.
module decode_control_pipe
    import cpu_ctrl_pkg::*;
#(
    parameter int STAGES = 1,
    parameter int ALUC_W = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    input  logic [31:0]       instr,
    input  logic              stall,
    input  logic              flush,
    output logic              valid_o,
    output logic              reg_write,
    output logic              mem_to_reg,
    output logic              mem_write,
    output logic              branch,
    output logic              branch_ne,
    output logic              jump,
    output logic              jump_reg,
    output logic              link,
    output logic [ALUC_W-1:0] alu_control,
    output logic              alu_src,
    output logic              alu_src_shamt,
    output logic              reg_dst,
    output logic              illegal,
    output logic [CNT_W-1:0]  illegal_count
);

    ctrl_word_t       dec_ctrl;
    logic             dec_illegal;
    stage_t           head_entry;
    stage_t           tail_entry;
    logic             accept_illegal;
    logic [CNT_W-1:0] illegal_count_reg;

    ctrl_decode u_decode (
        .instr   (instr),
        .ctrl    (dec_ctrl),
        .illegal (dec_illegal)
    );

    // Non-qualified cycles enter the chain as clean bubbles
    always_comb begin
        head_entry = STAGE_EMPTY;
        if (instr_valid) begin
            head_entry.valid   = 1'b1;
            head_entry.illegal = dec_illegal;
            head_entry.ctrl    = dec_ctrl;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            stage_t stage_next;
            stage_t stage_reg;

            if (gi == 0) begin : g_head
                assign stage_next = head_entry;
            end else begin : g_link
                assign stage_next = g_stage[gi-1].stage_reg;
            end

            // Stage register: reset and flush empty it, stall holds it
            always_ff @(posedge clk) begin
                if (rst) begin
                    stage_reg <= STAGE_EMPTY;
                end else if (flush) begin
                    stage_reg <= STAGE_EMPTY;
                end else if (!stall) begin
                    stage_reg <= stage_next;
                end
            end
        end
    endgenerate

    assign tail_entry = g_stage[STAGES-1].stage_reg;

    // Outputs come straight from the last stage, gated to zero on bubbles
    always_comb begin
        valid_o       = tail_entry.valid;
        reg_write     = 1'b0;
        mem_to_reg    = 1'b0;
        mem_write     = 1'b0;
        branch        = 1'b0;
        branch_ne     = 1'b0;
        jump          = 1'b0;
        jump_reg      = 1'b0;
        link          = 1'b0;
        alu_src       = 1'b0;
        alu_src_shamt = 1'b0;
        reg_dst       = 1'b0;
        illegal       = 1'b0;
        alu_control   = '0;
        if (tail_entry.valid) begin
            reg_write        = tail_entry.ctrl.reg_write;
            mem_to_reg       = tail_entry.ctrl.mem_to_reg;
            mem_write        = tail_entry.ctrl.mem_write;
            branch           = tail_entry.ctrl.branch;
            branch_ne        = tail_entry.ctrl.branch_ne;
            jump             = tail_entry.ctrl.jump;
            jump_reg         = tail_entry.ctrl.jump_reg;
            link             = tail_entry.ctrl.link;
            alu_src          = tail_entry.ctrl.alu_src;
            alu_src_shamt    = tail_entry.ctrl.alu_src_shamt;
            reg_dst          = tail_entry.ctrl.reg_dst;
            illegal          = tail_entry.illegal;
            alu_control[3:0] = tail_entry.ctrl.alu_ctrl;
        end
    end

    // An illegal entry counts once, at the moment it is accepted into stage 1
    assign accept_illegal = instr_valid && dec_illegal && !stall && !flush;

    // Saturating illegal-instruction counter; later flushes never undo a count
    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_count_reg <= '0;
        end else if (accept_illegal && (illegal_count_reg != '1)) begin
            illegal_count_reg <= illegal_count_reg + 1'b1;
        end
    end

    assign illegal_count = illegal_count_reg;

endmodule

// File: tb/tb_decode_control_pipe.sv
// Bench for decode_control_pipe: three instances (STAGES=1/CNT_W=2,
// STAGES=3, STAGES=2) share one stimulus stream. Directed table and corner
// sequences first, then a randomized run against a history-based model.
module tb_decode_control_pipe;

    // Packed view of one instance's outputs:
    // {valid, rw, m2r, mw, br, bne, j, jr, link, asrc, ashamt, rdst, ill, alu[3:0]}
    localparam logic [16:0] BUBBLE = 17'd0;
    localparam logic [16:0] E_ADD  = {1'b1, 12'b1000_0000_0010, 4'b0010};
    localparam logic [16:0] E_SUB  = {1'b1, 12'b1000_0000_0010, 4'b0110};
    localparam logic [16:0] E_LW   = {1'b1, 12'b1100_0000_1000, 4'b0010};
    localparam logic [16:0] E_BNE  = {1'b1, 12'b0001_1000_0000, 4'b1010};
    localparam logic [16:0] E_JAL  = {1'b1, 12'b1000_0101_0000, 4'b0000};
    localparam logic [16:0] E_ILL  = {1'b1, 12'b0000_0000_0001, 4'b1011};

    localparam int NVEC = 30;

    typedef struct packed {
        logic [31:0] instr;
        logic [11:0] ctrl;
        logic [3:0]  alu;
    } vec_t;

    vec_t tbl [NVEC];

    logic        clk;
    logic        rst;
    logic        instr_valid;
    logic [31:0] instr;
    logic        stall;
    logic        flush;

    logic [16:0] pk  [3];
    logic [7:0]  cnt [3];

    int tests;
    int fails;

    // Instance 0: STAGES=1, CNT_W=2; instance 1: STAGES=3; instance 2: STAGES=2
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_dut
            localparam int ST = (gi == 0) ? 1 : ((gi == 1) ? 3 : 2);
            localparam int CW = (gi == 0) ? 2 : 8;
            logic v, rw, m2r, mw, br, bne, j, jr, lnk, asrc, ash, rd, ill;
            logic [3:0]    alu;
            logic [CW-1:0] c;

            decode_control_pipe #(.STAGES(ST), .ALUC_W(4), .CNT_W(CW)) dut (
                .clk           (clk),
                .rst           (rst),
                .instr_valid   (instr_valid),
                .instr         (instr),
                .stall         (stall),
                .flush         (flush),
                .valid_o       (v),
                .reg_write     (rw),
                .mem_to_reg    (m2r),
                .mem_write     (mw),
                .branch        (br),
                .branch_ne     (bne),
                .jump          (j),
                .jump_reg      (jr),
                .link          (lnk),
                .alu_control   (alu),
                .alu_src       (asrc),
                .alu_src_shamt (ash),
                .reg_dst       (rd),
                .illegal       (ill),
                .illegal_count (c)
            );

            assign pk[gi]  = {v, rw, m2r, mw, br, bne, j, jr, lnk, asrc, ash, rd, ill, alu};
            assign cnt[gi] = 8'(c);
        end
    endgenerate

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp, input bit verbose);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end else if (verbose) begin
            $display("[TB] ok %s: %h", name, got);
        end
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        stall       = 1'b0;
        flush       = 1'b0;
        instr_valid = 1'b0;
        instr       = 32'h0;
        tick();
        rst = 1'b0;
    endtask

    task automatic issue(input logic [31:0] ins, input logic v);
        instr       = ins;
        instr_valid = v;
        tick();
    endtask

    // Reference decode: recognised encodings are those listed as legal in
    // the vector table (match op, and funct for op 0); anything else is illegal
    function automatic logic [16:0] ref_decode(input logic [31:0] ins);
        for (int k = 0; k < NVEC; k++) begin
            if (tbl[k].ctrl[0] == 1'b0 && tbl[k].instr[31:26] == ins[31:26] &&
                (ins[31:26] != 6'd0 || tbl[k].instr[5:0] == ins[5:0]))
                return {1'b1, tbl[k].ctrl, tbl[k].alu};
        end
        return E_ILL;
    endfunction

    initial begin
        logic [16:0] hist [$];
        int          cnt_m  [3];
        int          st_of  [3];
        int          maxc   [3];
        logic [31:0] rin;
        logic [16:0] rexp;

        tests = 0;
        fails = 0;
        st_of = '{1, 3, 2};
        maxc  = '{3, 255, 255};

        // ctrl = {rw,m2r,mw,br,bne,j,jr,link,asrc,ashamt,rdst,ill}
        tbl[0]  = '{32'h012A4020, 12'b1000_0000_0010, 4'b0010}; // add
        tbl[1]  = '{32'h012A4021, 12'b1000_0000_0010, 4'b0010}; // addu
        tbl[2]  = '{32'h012A4022, 12'b1000_0000_0010, 4'b0110}; // sub
        tbl[3]  = '{32'h012A4023, 12'b1000_0000_0010, 4'b0110}; // subu
        tbl[4]  = '{32'h012A4024, 12'b1000_0000_0010, 4'b0000}; // and
        tbl[5]  = '{32'h012A4025, 12'b1000_0000_0010, 4'b0001}; // or
        tbl[6]  = '{32'h012A4026, 12'b1000_0000_0010, 4'b0011}; // xor
        tbl[7]  = '{32'h012A4027, 12'b1000_0000_0010, 4'b1100}; // nor
        tbl[8]  = '{32'h012A402A, 12'b1000_0000_0010, 4'b0111}; // slt
        tbl[9]  = '{32'h000A4080, 12'b1000_0000_0110, 4'b0100}; // sll
        tbl[10] = '{32'h000A4082, 12'b1000_0000_0110, 4'b0101}; // srl
        tbl[11] = '{32'h000A4083, 12'b1000_0000_0110, 4'b1000}; // sra
        tbl[12] = '{32'h012A4004, 12'b1000_0000_0010, 4'b0100}; // sllv
        tbl[13] = '{32'h012A4006, 12'b1000_0000_0010, 4'b0101}; // srlv
        tbl[14] = '{32'h012A4007, 12'b1000_0000_0010, 4'b1000}; // srav
        tbl[15] = '{32'h03E00008, 12'b0000_0010_0000, 4'b0000}; // jr
        tbl[16] = '{32'h21090004, 12'b1000_0000_1000, 4'b0010}; // addi
        tbl[17] = '{32'h25090004, 12'b1000_0000_1000, 4'b0010}; // addiu
        tbl[18] = '{32'h31090004, 12'b1000_0000_1000, 4'b0000}; // andi
        tbl[19] = '{32'h35090004, 12'b1000_0000_1000, 4'b0001}; // ori
        tbl[20] = '{32'h39090004, 12'b1000_0000_1000, 4'b0011}; // xori
        tbl[21] = '{32'h8D090004, 12'b1100_0000_1000, 4'b0010}; // lw
        tbl[22] = '{32'hAD090004, 12'b0010_0000_1000, 4'b0010}; // sw
        tbl[23] = '{32'h11090003, 12'b0001_0000_0000, 4'b1001}; // beq
        tbl[24] = '{32'h15090003, 12'b0001_1000_0000, 4'b1010}; // bne
        tbl[25] = '{32'h08000010, 12'b0000_0100_0000, 4'b0000}; // j
        tbl[26] = '{32'h0C000010, 12'b1000_0101_0000, 4'b0000}; // jal
        tbl[27] = '{32'hFC000000, 12'b0000_0000_0001, 4'b1011}; // op 0x3F
        tbl[28] = '{32'h012A403F, 12'b0000_0000_0001, 4'b1011}; // funct 0x3F
        tbl[29] = '{32'h29090004, 12'b0000_0000_0001, 4'b1011}; // slti (unsupported)

        rst = 1'b1; stall = 1'b0; flush = 1'b0; instr_valid = 1'b0; instr = 32'h0;
        tick(); tick();

        // Reset state of every instance
        do_reset();
        for (int d = 0; d < 3; d++) begin
            check($sformatf("reset_out[%0d]", d), 32'(pk[d]), 32'(BUBBLE), 1'b1);
            check($sformatf("reset_cnt[%0d]", d), 32'(cnt[d]), 32'd0, 1'b1);
        end

        // Decode table through the single-stage instance
        for (int i = 0; i < NVEC; i++) begin
            issue(tbl[i].instr, 1'b1);
            check($sformatf("decode[%0d] %h", i, tbl[i].instr), 32'(pk[0]),
                  32'({1'b1, tbl[i].ctrl, tbl[i].alu}), 1'b1);
        end
        issue(32'h0, 1'b0);
        check("bubble_after_table", 32'(pk[0]), 32'(BUBBLE), 1'b1);

        // add with STAGES=1 appears one cycle after issue
        do_reset();
        issue(32'h012A4020, 1'b1);
        check("add_s1", 32'(pk[0]), 32'(E_ADD), 1'b1);

        // lw then bne back-to-back through STAGES=3
        do_reset();
        issue(32'h8D090004, 1'b1);
        issue(32'h15090003, 1'b1);
        check("s3_empty_at_2", 32'(pk[1]), 32'(BUBBLE), 1'b1);
        issue(32'h0, 1'b0);
        check("s3_lw_at_3", 32'(pk[1]), 32'(E_LW), 1'b1);
        issue(32'h0, 1'b0);
        check("s3_bne_at_4", 32'(pk[1]), 32'(E_BNE), 1'b1);

        // jal followed by a 2-cycle stall; valid add offered during stall is ignored
        do_reset();
        issue(32'h0C000010, 1'b1);
        check("jal_s1_issue", 32'(pk[0]), 32'(E_JAL), 1'b1);
        stall = 1'b1;
        for (int k = 0; k < 2; k++) begin
            issue(32'h012A4020, 1'b1);
            check($sformatf("jal_s1_frozen%0d", k), 32'(pk[0]), 32'(E_JAL), 1'b1);
            check($sformatf("jal_s2_frozen%0d", k), 32'(pk[2]), 32'(BUBBLE), 1'b1);
            check($sformatf("jal_s3_frozen%0d", k), 32'(pk[1]), 32'(BUBBLE), 1'b1);
        end
        stall = 1'b0;
        issue(32'h0, 1'b0);
        check("jal_s1_drained", 32'(pk[0]), 32'(BUBBLE), 1'b1);
        check("jal_s2_late", 32'(pk[2]), 32'(E_JAL), 1'b1);
        check("jal_s3_midway", 32'(pk[1]), 32'(BUBBLE), 1'b1);
        issue(32'h0, 1'b0);
        check("jal_s3_late", 32'(pk[1]), 32'(E_JAL), 1'b1);

        // flush with stall, two entries in flight in STAGES=2
        do_reset();
        issue(32'h012A4020, 1'b1);
        issue(32'h012A4022, 1'b1);
        check("s2_add_before_flush", 32'(pk[2]), 32'(E_ADD), 1'b1);
        flush = 1'b1; stall = 1'b1;
        issue(32'h012A4020, 1'b1);
        check("flush_cycle1", 32'(pk[2]), 32'(BUBBLE), 1'b1);
        flush = 1'b0; stall = 1'b0;
        issue(32'h0, 1'b0);
        check("flush_cycle2", 32'(pk[2]), 32'(BUBBLE), 1'b1);

        // Saturating illegal counter with CNT_W=2
        do_reset();
        for (int k = 0; k < 5; k++) begin
            issue(32'hFC000000, 1'b1);
            check($sformatf("illegal_out%0d", k), 32'(pk[0]), 32'(E_ILL), 1'b1);
            check($sformatf("illegal_cnt%0d", k), 32'(cnt[0]), (k < 3) ? k + 1 : 3, 1'b1);
        end
        // A flushed illegal keeps its count
        flush = 1'b1;
        issue(32'h0, 1'b0);
        flush = 1'b0;
        check("cnt_kept_after_flush", 32'(cnt[1]), 32'd5, 1'b1);

        // Reset mid-stream while stalled
        do_reset();
        issue(32'hFC000000, 1'b1);
        issue(32'h012A4020, 1'b1);
        rst = 1'b1; stall = 1'b1;
        issue(32'hFC000000, 1'b1);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("rst_mid_out[%0d]", d), 32'(pk[d]), 32'(BUBBLE), 1'b1);
            check($sformatf("rst_mid_cnt[%0d]", d), 32'(cnt[d]), 32'd0, 1'b1);
        end
        check("rst_mid_alu", 32'(pk[1][3:0]), 32'd0, 1'b1);
        rst = 1'b0; stall = 1'b0; instr_valid = 1'b0;

        // Randomized run against a history model: each instance shows the entry
        // accepted STAGES advances ago; flush and reset erase the history window
        do_reset();
        hist.delete();
        for (int k = 0; k < 4; k++) hist.push_back(BUBBLE);
        cnt_m = '{0, 0, 0};
        for (int it = 0; it < 400; it++) begin
            if ($urandom_range(0, 1) == 1) begin
                rin = tbl[$urandom_range(0, NVEC - 1)].instr;
                if (rin[31:26] == 6'd0) rin = rin ^ ($urandom & 32'h03FF_FFC0);
                else                    rin = rin ^ ($urandom & 32'h03FF_FFFF);
            end else begin
                rin = $urandom;
            end
            rst         = ($urandom_range(0, 99) < 2);
            flush       = ($urandom_range(0, 99) < 6);
            stall       = ($urandom_range(0, 99) < 20);
            instr_valid = ($urandom_range(0, 99) < 70);
            instr       = rin;
            rexp        = ref_decode(rin);

            if (rst) begin
                for (int k = 1; k <= 4; k++) hist[hist.size() - k] = BUBBLE;
                cnt_m = '{0, 0, 0};
            end else if (flush) begin
                for (int k = 1; k <= 4; k++) hist[hist.size() - k] = BUBBLE;
            end else if (!stall) begin
                hist.push_back(instr_valid ? rexp : BUBBLE);
                if (instr_valid && rexp[4]) begin
                    for (int d = 0; d < 3; d++)
                        if (cnt_m[d] < maxc[d]) cnt_m[d]++;
                end
            end
            if (hist.size() > 8) void'(hist.pop_front());

            $display("[TB] rnd %0d instr=%h v=%b stall=%b flush=%b rst=%b",
                     it, rin, instr_valid, stall, flush, rst);
            tick();
            for (int d = 0; d < 3; d++) begin
                check($sformatf("rnd%0d_out[%0d]", it, d), 32'(pk[d]),
                      32'(hist[hist.size() - st_of[d]]), 1'b0);
                check($sformatf("rnd%0d_cnt[%0d]", it, d), 32'(cnt[d]),
                      32'(cnt_m[d]), 1'b0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
